char_normalizer: RTL and testbench
==================================

# char_normalizer

Upstream front end for the block-keyword checker. Accepts raw ASCII bytes over a valid/ready handshake, normalises them (case fold, whitespace mapping, space-run collapsing), buffers them in an 8-entry FIFO and presents one normalised character per transfer to the checker. On end-of-stream it guarantees a single terminating space so the checker always sees the final word closed.

## Interface

- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `AW`, 3: log2(DEPTH).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  raw ASCII byte.
- `in_last`  in  1  marks the final byte of a stream; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a byte this cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  8  normalised character at FIFO head.
- `out_last`  out  1  head entry is the stream terminator.
- `out_ready`  in  1  downstream consumes head this cycle.

## Operation

- Accept: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Normalisation (combinational on `in_data`):
  - 0x41–0x5A (A–Z) → +0x20 (a–z).
  - 0x09, 0x0A, 0x0D, 0x20 → 0x20.
  - All other bytes pass unchanged.
- Collapse flag `prev_space`, reset value 1:
  - Accepted normalised space with `prev_space=1` and `in_last=0`: dropped (consumed, not enqueued). This also strips leading spaces.
  - Any other accepted byte is enqueued as {last, char}. `prev_space` becomes (char==0x20).
- End of stream: on accept with `in_last=1`:
  - If the normalised char is a space, enqueue {1,0x20} regardless of `prev_space`. This is the only case that can emit two consecutive spaces.
  - If it is not a space, enqueue {0,char} and enter PAD.
  - In both cases `prev_space` returns to 1 for the next stream.
- FSM, two states:
  - ACCEPT (reset state): `in_ready = (count <= DEPTH-2)`, so there is always room for a pad entry.
  - PAD: `in_ready=0`. Enqueue {1,0x20}, then return to ACCEPT after one cycle, independent of `out_ready`.
- FIFO:
  - `wr_ptr` and `rd_ptr` are AW bits and wrap modulo DEPTH.
  - `count` is AW+1 bits.
  - Simultaneous push and pop leave `count` unchanged. The popped entry is the old head.
  - A push into an empty FIFO while a pop is attempted is impossible, because `out_valid=0` then.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_data` and `out_last` come from the head entry when `out_valid=1`; otherwise 0x00 and 0.
  - Downstream must advance only on a pop.
- Reset (asynchronous, any time, including during PAD or mid-stream): pointers, count and state are cleared, `prev_space` is set to 1, and the FIFO contents are discarded.

## Timing

- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0x00`, `out_last=0`.
- Latency: a byte accepted at edge N appears at the head after edge N if the FIFO was empty, i.e. `out_valid=1` during cycle N+1.
- Pad entry: written at the edge ending the PAD cycle and visible one cycle after its predecessor at the earliest.
- Throughput: one accept and one pop per cycle sustained. After a non-space `in_last` there is exactly one bubble cycle on the input side (PAD).
- `in_ready` is combinational from state and `count` only, not from `in_valid` or `out_ready`.
- Full: with `count = DEPTH-1` or `DEPTH`, `in_ready=0` even if a pop occurs in the same cycle.

## Test plan

- Reset/idle: hold `reset=0`, then release → `in_ready=1`, `out_valid=0`, `out_data=0x00`; no entries appear with `in_valid=0`.
- Normalise/collapse: with `out_ready=1`, send "  BeGin\t\tEnD" with `in_last` on 'D' → output stream is "begin end ", with `out_last=1` only on the final 0x20. The input sees exactly one `in_ready=0` cycle after 'D'.
- Space terminator: send "end  " with `in_last` on the last space → output "end  " (two spaces), the last one flagged; no PAD cycle occurs.
- Backpressure/full: `out_ready=0`, send 10 letters 'a'..'j' → exactly 7 accepted ('a'..'g'), then `in_ready=0`. Release `out_ready` → 'a'..'g' come out in order, then 'h','i','j' are accepted and emitted with no loss or duplication.
- Wrap and simultaneous push/pop: stream 40 non-space bytes with `out_ready` toggling on a fixed pattern → output matches the case-folded input exactly, and `count` never exceeds 8.
- Mid-operation reset: assert `reset=0` during PAD with 5 entries queued → `out_valid` drops immediately (asynchronously). After release, the FIFO is empty, a leading space is dropped, and "x" followed by a pad produces "x " with `out_last` on the space.

Source files
------------

// File: rtl/char_normalizer.sv
// Byte normaliser in front of the block-keyword checker: case fold, whitespace
// mapping, space-run collapsing and end-of-stream space padding into a small FIFO.
module char_normalizer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic         out_last,
  input  logic         out_ready
);

  localparam int unsigned NW    = AW + 1;
  localparam logic [7:0]  SPACE = 8'h20;

  typedef struct packed {
    logic       last;
    logic [7:0] ch;
  } entry_t;

  typedef enum logic {ACCEPT, PAD} state_t;

  state_t          state, state_nxt;
  logic            prev_space, prev_space_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;
  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic            push, pop, accept;
  logic [7:0]      norm;
  logic            norm_is_space;

  // Character normalisation of the incoming byte
  always_comb begin
    norm = in_data;
    if (in_data >= 8'h41 && in_data <= 8'h5A)
      norm = in_data + 8'h20;
    else if (in_data == 8'h09 || in_data == 8'h0A || in_data == 8'h0D || in_data == 8'h20)
      norm = SPACE;
  end

  assign norm_is_space = (norm == SPACE);
  // Two free slots required so a pad entry always fits behind the last byte
  assign in_ready  = (state == ACCEPT) && (count <= NW'(DEPTH - 2));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Next-state, collapse flag and FIFO write decision
  always_comb begin
    state_nxt      = state;
    prev_space_nxt = prev_space;
    push           = 1'b0;
    wr_entry       = '0;
    case (state)
      ACCEPT: begin
        if (accept) begin
          if (in_last) begin
            push           = 1'b1;
            wr_entry       = '{last: norm_is_space, ch: norm};
            prev_space_nxt = 1'b1;
            if (!norm_is_space) state_nxt = PAD;
          end else if (!(norm_is_space && prev_space)) begin
            push           = 1'b1;
            wr_entry       = '{last: 1'b0, ch: norm};
            prev_space_nxt = norm_is_space;
          end
        end
      end
      PAD: begin
        push      = 1'b1;
        wr_entry  = '{last: 1'b1, ch: SPACE};
        state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ACCEPT;
      prev_space <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      prev_space <= prev_space_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.ch   : 8'h00;
  assign out_last = out_valid ? head.last : 1'b0;

endmodule

// File: tb/tb_char_normalizer.sv
// Directed bench for char_normalizer: per-byte normalisation table plus
// hand-written stream, backpressure, wrap and mid-PAD reset sequences.
module tb_char_normalizer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;
  logic [8:0] got [$];

  char_normalizer #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Record every pop: inputs only change just after posedge, so the negedge
  // view matches the decision taken at the following edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got.push_back({out_last, out_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic acc;
    bit   ok;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin ok = 1; break; end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_got(input string name, input int n);
    for (int c = 0; c < 200; c++) begin
      if (got.size() >= n) break;
      tick();
    end
    chk(name, got.size(), n);
  endtask

  function automatic logic [7:0] lc(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? 8'(b + 8'h20) : b;
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t       vecs [12];
    string      s;
    string      e;
    logic [7:0] src [40];
    logic       acc;
    int         n_acc;
    int         idx;
    int         maxc;
    logic       is_sp;

    vecs[0]  = '{8'h41, 8'h61};  vecs[1]  = '{8'h5A, 8'h7A};
    vecs[2]  = '{8'h40, 8'h40};  vecs[3]  = '{8'h5B, 8'h5B};
    vecs[4]  = '{8'h61, 8'h61};  vecs[5]  = '{8'h09, 8'h20};
    vecs[6]  = '{8'h0A, 8'h20};  vecs[7]  = '{8'h0D, 8'h20};
    vecs[8]  = '{8'h20, 8'h20};  vecs[9]  = '{8'h0B, 8'h0B};
    vecs[10] = '{8'hC1, 8'hC1};  vecs[11] = '{8'h4D, 8'h6D};

    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;

    // Reset / idle
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_last",  32'(out_last),  32'd0);
    tick(); tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Per-byte normalisation, each byte sent as a one-byte stream
    for (int i = 0; i < 12; i++) begin
      got.delete();
      out_ready = 1'b0;
      send(vecs[i].din, 1'b1);
      is_sp = (vecs[i].exp == 8'h20);
      @(negedge clk);
      chk("vec_head_valid", 32'(out_valid), 32'd1);
      chk("vec_head_data",  32'(out_data),  32'(vecs[i].exp));
      chk("vec_head_last",  32'(out_last),  32'(is_sp));
      chk("vec_pad_ready",  32'(in_ready),  32'(is_sp));
      tick();
      out_ready = 1'b1;
      wait_got("vec_count", is_sp ? 1 : 2);
      chk("vec_entry0", 32'(got[0]), 32'({is_sp, vecs[i].exp}));
      if (!is_sp) chk("vec_pad_entry", 32'(got[1]), 32'h120);
    end

    // Leading strip, collapse, case fold and pad
    got.delete();
    out_ready = 1'b1;
    s = "  BeGin\t\tEnD";
    e = "begin end ";
    for (int i = 0; i < s.len(); i++) send(s[i], 1'(i == s.len() - 1));
    @(negedge clk);
    chk("pad_bubble", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("pad_done_ready", 32'(in_ready), 32'd1);
    tick();
    wait_got("stream1_count", e.len());
    for (int i = 0; i < e.len(); i++)
      chk("stream1_char", 32'(got[i]), 32'({1'(i == e.len() - 1), e[i]}));
    tick(); tick(); tick();
    chk("stream1_nodup", got.size(), e.len());

    // Trailing space as the terminator: no pad
    got.delete();
    s = "end  ";
    for (int i = 0; i < s.len(); i++) send(s[i], 1'(i == s.len() - 1));
    @(negedge clk);
    chk("nopad_ready", 32'(in_ready), 32'd1);
    tick();
    wait_got("stream2_count", 5);
    for (int i = 0; i < 5; i++)
      chk("stream2_char", 32'(got[i]), 32'({1'(i == 4), s[i]}));

    // Backpressure until full
    got.delete();
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + n_acc); in_last = 1'b0;
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) n_acc++;
    end
    in_valid = 1'b0;
    chk("full_accepted", n_acc, 7);
    @(negedge clk);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head",  32'(out_data), 32'h61);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_pop", 32'(in_ready), 32'd0);
    tick();
    send(8'h68, 1'b0); send(8'h69, 1'b0); send(8'h6A, 1'b0);
    wait_got("full_count", 10);
    for (int i = 0; i < 10; i++)
      chk("full_order", 32'(got[i]), 32'(8'h61 + i));
    tick(); tick(); tick();
    chk("full_nodup", got.size(), 10);

    // Wrap-around with a toggling consumer
    got.delete();
    for (int i = 0; i < 40; i++)
      src[i] = (i % 5 == 4) ? 8'(8'h30 + i % 10) :
               (i % 2 == 1) ? 8'(8'h41 + i % 26) : 8'(8'h61 + i % 26);
    idx = 0; maxc = 0;
    for (int c = 0; c < 400 && idx < 40; c++) begin
      out_ready = (c % 4 != 1) && (c % 7 != 3);
      in_valid = 1'b1; in_data = src[idx]; in_last = 1'b0;
      @(negedge clk);
      acc = in_ready;
      if (int'(dut.count) > maxc) maxc = int'(dut.count);
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("wrap_sent", idx, 40);
    chk("wrap_max_count", 32'(maxc <= 8), 32'd1);
    wait_got("wrap_count", 40);
    for (int i = 0; i < 40; i++)
      chk("wrap_char", 32'(got[i]), 32'({1'b0, lc(src[i])}));

    // Reset while in PAD with 5 entries queued
    got.delete();
    out_ready = 1'b0;
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b0);
    send(8'h65, 1'b1);
    @(negedge clk);
    chk("mid_pad_ready", 32'(in_ready),  32'd0);
    chk("mid_pad_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'h00);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    tick();
    got.delete();
    out_ready = 1'b1;
    send(8'h20, 1'b0);
    send(8'h78, 1'b1);
    wait_got("post_rst_count", 2);
    chk("post_rst_x",   32'(got[0]), 32'h078);
    chk("post_rst_pad", 32'(got[1]), 32'h120);
    tick(); tick(); tick();
    chk("post_rst_nodup", got.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
